// File: rtl/sample_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sample_bridge
// Purpose  : Frame-paced serial ADC/DAC bridge feeding an adaptive filter.
//            Captures one sample per frame and hands it to the filter. The
//            filter result is returned to the DAC in the following frame.
// Revision : 1.0 - initial release
// ============================================================================
module sample_bridge #(
  parameter int DATA_SIZE = 24,
  parameter int BCLK_DIV  = 2,
  parameter int FRAME_CYC = 256,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_sdata,
  output logic                 adc_cs_n,
  output logic                 sclk,
  output logic                 dac_sdata,
  output logic                 dac_ld,
  output logic [DATA_SIZE-1:0] data_in,
  output logic                 sample_trig,
  input  logic                 filter_done,
  input  logic [DATA_SIZE-1:0] data_out,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int c_FRAME_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int c_DIV_W   = (BCLK_DIV > 0) ? $clog2(2 * BCLK_DIV) : 1;
  localparam int c_BIT_W   = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int c_WAIT_W  = $clog2(TIMEOUT + 1);

  localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(FRAME_CYC - 1);
  localparam logic [c_FRAME_W-1:0] c_FRAME_ONE  = c_FRAME_W'(1);
  localparam logic [c_DIV_W-1:0]   c_DIV_RISE   = c_DIV_W'(BCLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]   c_DIV_SAMP   = c_DIV_W'(BCLK_DIV);
  localparam logic [c_DIV_W-1:0]   c_DIV_LAST   = c_DIV_W'(2 * BCLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]   c_DIV_ONE    = c_DIV_W'(1);
  localparam logic [c_BIT_W-1:0]   c_BIT_LAST   = c_BIT_W'(DATA_SIZE - 1);
  localparam logic [c_BIT_W-1:0]   c_BIT_ONE    = c_BIT_W'(1);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(TIMEOUT - 1);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE   = c_WAIT_W'(1);

  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_CONV    = 3'd1;
  localparam logic [2:0] c_S_TRIG    = 3'd2;
  localparam logic [2:0] c_S_WAIT    = 3'd3;
  localparam logic [2:0] c_S_CAPTURE = 3'd4;
  localparam logic [2:0] c_S_GAP     = 3'd5;

  logic [2:0]           r_state;
  logic [c_FRAME_W-1:0] r_frame_cnt;
  logic [c_DIV_W-1:0]   r_div_cnt;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [c_WAIT_W-1:0]  r_wait_cnt;
  logic [DATA_SIZE-1:0] r_rx;
  logic [DATA_SIZE-1:0] r_tx;
  logic [DATA_SIZE-1:0] r_dac_shift;
  logic [DATA_SIZE-1:0] r_data_in;
  logic                 r_adc_cs_n;
  logic                 r_sclk;
  logic                 r_dac_sdata;
  logic                 r_dac_ld;
  logic                 r_sample_trig;
  logic                 r_overrun;
  logic                 r_timeout_err;

  logic                 w_tick;
  logic                 w_busy;
  logic                 w_sample_now;
  logic [DATA_SIZE-1:0] w_rx_shifted;
  logic [DATA_SIZE-1:0] w_rx_next;

  assign w_tick       = (r_frame_cnt == c_FRAME_LAST);
  assign w_busy       = (r_state != c_S_IDLE) && (r_state != c_S_GAP);
  assign w_sample_now = (r_state == c_S_CONV) && (r_div_cnt == c_DIV_SAMP);
  assign w_rx_shifted = {r_rx[DATA_SIZE-2:0], adc_sdata};
  // With BCLK_DIV=1 the last sample and the end of CONV coincide, so the
  // word handed to data_in must include the bit being sampled this cycle.
  assign w_rx_next    = w_sample_now ? w_rx_shifted : r_rx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + c_FRAME_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_S_IDLE;
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_dac_shift   <= '0;
      r_data_in     <= '0;
      r_adc_cs_n    <= 1'b1;
      r_sclk        <= 1'b0;
      r_dac_sdata   <= 1'b0;
      r_dac_ld      <= 1'b0;
      r_sample_trig <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dac_ld      <= 1'b0;
      r_sample_trig <= 1'b0;
      r_rx          <= w_rx_next;

      if (w_tick && w_busy) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        c_S_IDLE, c_S_GAP: begin
          if (w_tick) begin
            r_state     <= c_S_CONV;
            r_adc_cs_n  <= 1'b0;
            r_sclk      <= 1'b0;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_dac_sdata <= r_tx[DATA_SIZE-1];
            r_dac_shift <= {r_tx[DATA_SIZE-2:0], 1'b0};
          end
        end

        c_S_CONV: begin
          r_div_cnt <= r_div_cnt + c_DIV_ONE;
          if (r_div_cnt == c_DIV_RISE) begin
            r_sclk <= 1'b1;
          end
          if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            if (r_bit_cnt == c_BIT_LAST) begin
              r_state       <= c_S_TRIG;
              r_adc_cs_n    <= 1'b1;
              r_dac_sdata   <= 1'b0;
              r_dac_ld      <= 1'b1;
              r_sample_trig <= 1'b1;
              r_data_in     <= w_rx_next;
            end else begin
              r_bit_cnt   <= r_bit_cnt + c_BIT_ONE;
              r_dac_sdata <= r_dac_shift[DATA_SIZE-1];
              r_dac_shift <= {r_dac_shift[DATA_SIZE-2:0], 1'b0};
            end
          end
        end

        // The wait counter is seeded with 1 so that it equals the number of
        // cycles elapsed since the sample_trig cycle.
        c_S_TRIG: begin
          r_state    <= c_S_WAIT;
          r_wait_cnt <= c_WAIT_ONE;
        end

        c_S_WAIT: begin
          if (filter_done) begin
            r_state <= c_S_CAPTURE;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= c_S_GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
          end
        end

        c_S_CAPTURE: begin
          r_tx    <= data_out;
          r_state <= c_S_GAP;
        end

        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  assign adc_cs_n    = r_adc_cs_n;
  assign sclk        = r_sclk;
  assign dac_sdata   = r_dac_sdata;
  assign dac_ld      = r_dac_ld;
  assign data_in     = r_data_in;
  assign sample_trig = r_sample_trig;
  assign busy        = w_busy;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_sample_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_bridge
// Purpose  : Scoreboard bench for sample_bridge (default build plus a short
//            FRAME_CYC=100 build that must report overrun).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_bridge;

  localparam int DW = 24;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;

  logic          adc_sdata, adc_cs_n, sclk, dac_sdata, dac_ld, sample_trig;
  logic          filter_done, busy, overrun, timeout_err;
  logic [DW-1:0] data_in, data_out;

  logic          adc_sdata2, adc_cs_n2, sclk2, dac_sdata2, dac_ld2, sample_trig2;
  logic          filter_done2, busy2, overrun2, timeout_err2;
  logic [DW-1:0] data_in2, data_out2;

  always #5 clk = ~clk;

  sample_bridge dut (
    .clk(clk), .reset(reset), .adc_sdata(adc_sdata), .adc_cs_n(adc_cs_n),
    .sclk(sclk), .dac_sdata(dac_sdata), .dac_ld(dac_ld), .data_in(data_in),
    .sample_trig(sample_trig), .filter_done(filter_done), .data_out(data_out),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  sample_bridge #(.FRAME_CYC(100)) dut2 (
    .clk(clk), .reset(reset), .adc_sdata(adc_sdata2), .adc_cs_n(adc_cs_n2),
    .sclk(sclk2), .dac_sdata(dac_sdata2), .dac_ld(dac_ld2), .data_in(data_in2),
    .sample_trig(sample_trig2), .filter_done(filter_done2), .data_out(data_out2),
    .busy(busy2), .overrun(overrun2), .timeout_err(timeout_err2)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] q_din[$];
  logic [DW-1:0] q_dac[$];

  logic [DW-1:0] adc_word   = '0;
  logic          f_respond  = 1'b0;
  logic [DW-1:0] f_resp     = '0;
  int            spur_cnt   = 0;
  logic [DW-1:0] tx_model   = '0;
  logic          err_model  = 1'b0;
  bit            dac_idle_bad = 1'b0;
  bit            dut2_done  = 1'b0;
  logic [DW-1:0] dac2_word  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model: MSB presented at frame start, next bit after each sclk fall.
  initial begin
    int n;
    logic prev;
    n = 0; prev = 1'b0; adc_sdata = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_cs_n) begin
        n = 0; prev = 1'b0;
      end else begin
        if (prev && !sclk && n < DW - 1) n++;
        prev = sclk;
      end
      adc_sdata = adc_word[DW-1-n];
    end
  end

  initial begin
    int n;
    logic prev;
    logic [DW-1:0] w2;
    n = 0; prev = 1'b0; adc_sdata2 = 1'b0; w2 = 24'hC0FFEE;
    forever begin
      @(negedge clk);
      if (adc_cs_n2) begin
        n = 0; prev = 1'b0;
      end else begin
        if (!prev && sclk2) dac2_word = {dac2_word[DW-2:0], dac_sdata2};
        if (prev && !sclk2 && n < DW - 1) n++;
        prev = sclk2;
      end
      adc_sdata2 = w2[DW-1-n];
    end
  end

  // Filter models: a one-cycle filter_done pulse with data_out held afterwards.
  initial begin
    int spur_seen;
    spur_seen = 0; filter_done = 1'b0; data_out = '0;
    forever begin
      @(negedge clk);
      if (!reset && sample_trig && f_respond) begin
        @(posedge clk); #1 data_out = f_resp; filter_done = 1'b1;
        @(posedge clk); #1 filter_done = 1'b0;
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        @(posedge clk); #1 data_out = 24'hDEAD00; filter_done = 1'b1;
        @(posedge clk); #1 filter_done = 1'b0;
      end
    end
  end

  initial begin
    filter_done2 = 1'b0; data_out2 = '0;
    forever begin
      @(negedge clk);
      if (!reset && sample_trig2) begin
        repeat (4) @(posedge clk);
        #1 data_out2 = 24'h654321; filter_done2 = 1'b1;
        @(posedge clk); #1 filter_done2 = 1'b0;
      end
    end
  end

  // Monitor for the default build: frame timing, DAC word, scoreboard pops.
  initial begin
    int cyc, low_cnt, rise_cnt, last_start;
    logic prev_cs, prev_sclk;
    logic [DW-1:0] dac_word, exp_v;
    cyc = 0; low_cnt = 0; rise_cnt = 0; last_start = -1;
    prev_cs = 1'b1; prev_sclk = 1'b0; dac_word = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        low_cnt = 0; rise_cnt = 0; last_start = -1;
        prev_cs = 1'b1; prev_sclk = 1'b0;
      end else begin
        if (prev_cs && !adc_cs_n) begin
          if (last_start >= 0) check("frame_period", cyc - last_start, 256);
          last_start = cyc; low_cnt = 0; rise_cnt = 0; dac_word = '0;
        end
        if (!adc_cs_n) begin
          low_cnt++;
          if (sclk && !prev_sclk) begin
            rise_cnt++;
            dac_word = {dac_word[DW-2:0], dac_sdata};
          end
        end else if (dac_sdata || sclk) begin
          dac_idle_bad = 1'b1;
        end
        if (!prev_cs && adc_cs_n) begin
          check("cs_low_cycles", low_cnt, 96);
          check("sclk_rises", rise_cnt, 24);
        end
        if (sample_trig) begin
          if (q_din.size() == 0) check("unexpected_trig", sample_trig, 0);
          else begin exp_v = q_din.pop_front(); check("data_in", data_in, exp_v); end
        end
        if (dac_ld) begin
          if (q_dac.size() == 0) check("unexpected_dac_ld", dac_ld, 0);
          else begin exp_v = q_dac.pop_front(); check("dac_word", dac_word, exp_v); end
        end
        prev_cs = adc_cs_n; prev_sclk = sclk;
      end
    end
  end

  task automatic run_frame(input logic [DW-1:0] a, input bit en, input logic [DW-1:0] r,
                           input bit rel, output int lat);
    int k;
    adc_word = a; f_respond = en; f_resp = r;
    q_din.push_back(a);
    q_dac.push_back(tx_model);
    if (en) tx_model = r;
    else    err_model = 1'b1;
    if (rel) reset = 1'b0;
    lat = 0;
    while (lat < 700) begin
      @(negedge clk); lat++;
      if (sample_trig) break;
    end
    check("trig_seen", sample_trig, 1);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (k == 0 && timeout_err) k = i;
    end
    if (!en) check("timeout_delay", k, 16);
    check("timeout_err", timeout_err, err_model);
    check("gap_busy", busy, 0);
  endtask

  initial begin
    int lat, n, rises;
    logic prev;
    repeat (3) @(negedge clk);
    check("reset_ctl", {adc_cs_n, sclk, dac_sdata, dac_ld, sample_trig, busy, overrun, timeout_err}, 8'h80);
    check("reset_data_in", data_in, 0);

    run_frame(24'h800001, 1'b1, 24'h123456, 1'b1, lat);
    check("first_trig_latency", lat, 352);
    run_frame(24'h7FFFFF, 1'b1, 24'hA5C3E1, 1'b0, lat);
    check("trig_spacing", lat, 226);

    spur_cnt++;
    repeat (5) @(negedge clk);
    check("spur_timeout_err", timeout_err, 0);
    check("spur_overrun", overrun, 0);

    run_frame(24'hFFFFFF, 1'b1, 24'h0F0F0F, 1'b0, lat);
    run_frame(24'h5A5A5A, 1'b0, 24'h000000, 1'b0, lat);
    run_frame(24'h000001, 1'b1, 24'h3C0FF1, 1'b0, lat);

    // Abort a frame partway through bit 10 with an asynchronous reset.
    adc_word = 24'hAAAAAA; f_respond = 1'b0;
    n = 0;
    while (adc_cs_n && n < 400) begin @(negedge clk); n++; end
    check("abort_frame_start", adc_cs_n, 0);
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 10 && n < 200) begin
      @(negedge clk); n++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_timeout_err", timeout_err, 1);
    reset = 1'b1;
    #1;
    check("abort_ctl", {adc_cs_n, sclk, dac_sdata, dac_ld, sample_trig, busy, overrun, timeout_err}, 8'h80);
    check("abort_data_in", data_in, 0);
    repeat (3) @(negedge clk);
    tx_model = '0; err_model = 1'b0;
    run_frame(24'h555555, 1'b1, 24'h111111, 1'b1, lat);
    check("post_reset_trig_latency", lat, 352);

    n = 0;
    while (!dut2_done && n < 2000) begin @(negedge clk); n++; end
    check("dut2_finished", dut2_done, 1);
    check("overrun_default", overrun, 0);
    check("dac_idle_low", dac_idle_bad, 0);
    check("scoreboard_empty", q_din.size() + q_dac.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Short-frame build: the tick during WAIT_DONE must raise overrun only.
  initial begin
    int n;
    wait (reset == 1'b0);
    n = 0;
    while (n < 400) begin @(negedge clk); n++; if (sample_trig2) break; end
    check("d2_trig1_latency", n, 196);
    check("d2_data_in1", data_in2, 24'hC0FFEE);
    check("d2_overrun_pre", overrun2, 0);
    repeat (10) @(negedge clk);
    check("d2_overrun_set", overrun2, 1);
    n = 0;
    while (n < 400) begin @(negedge clk); n++; if (sample_trig2) break; end
    check("d2_trig_spacing", n, 190);
    check("d2_data_in2", data_in2, 24'hC0FFEE);
    check("d2_dac_ld", dac_ld2, 1);
    check("d2_dac_word", dac2_word, 24'h654321);
    check("d2_timeout_err", timeout_err2, 0);
    dut2_done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sample_bridge.md
SAMPLE_BRIDGE -- requirements
Module: sample_bridge

Interface
REQ-001 Parameter DATA_SIZE, default 24: sample width, two's complement, equal to filter data width.
REQ-002 Parameter BCLK_DIV, default 2: sclk half-period in clk cycles; allowed values ≥1.
REQ-003 Parameter FRAME_CYC, default 256: sample period in clk cycles (10 MHz/256 ≈ 39.06 kHz); SHALL be ≥ 2*BCLK_DIV*DATA_SIZE + TIMEOUT + 4.
REQ-004 Parameter TIMEOUT, default 16: maximum clk cycles to wait for filter_done after sample_trig.
REQ-005 clk  input  1  system clock, 10 MHz, rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 adc_sdata  input  1  serial ADC data, MSB first.
REQ-008 adc_cs_n  output  1  ADC chip select, low during conversion frame.
REQ-009 sclk  output  1  serial bit clock shared by ADC and DAC, idle low.
REQ-010 dac_sdata  output  1  serial DAC data, MSB first.
REQ-011 dac_ld  output  1  one-cycle DAC latch pulse.
REQ-012 data_in  output  DATA_SIZE  sample to adaptive filter.
REQ-013 sample_trig  output  1  one-cycle pulse, new sample on data_in.
REQ-014 filter_done  input  1  filter acknowledge pulse.
REQ-015 data_out  input  DATA_SIZE  filtered sample from filter.
REQ-016 busy  output  1  high in any state other than IDLE/GAP.
REQ-017 overrun  output  1  sticky: frame tick missed.
REQ-018 timeout_err  output  1  sticky: filter_done not received in time.

Function
REQ-019 Frame counter SHALL count 0..FRAME_CYC-1 and wrap, free-running from reset release; frame tick when count = FRAME_CYC-1.
REQ-020 FSM states: IDLE, CONV, TRIG, WAIT_DONE, CAPTURE, GAP; IDLE exits to CONV on first frame tick.
REQ-021 CONV: adc_cs_n low; DATA_SIZE bit periods, each sclk low BCLK_DIV cycles then high BCLK_DIV cycles.
REQ-022 adc_sdata SHALL be sampled in the clk cycle sclk goes high, shifted in MSB first.
REQ-023 dac_sdata SHALL update at the start of each bit period (sclk low), shifting out the tx register MSB first; dac_sdata = 0 outside CONV.
REQ-024 After last sclk high phase: adc_cs_n high, dac_ld pulses 1 cycle, FSM enters TRIG.
REQ-025 TRIG (1 cycle): data_in loaded with received word, sample_trig = 1; data_in SHALL then hold stable until the next TRIG.
REQ-026 WAIT_DONE: on filter_done = 1 go to CAPTURE; after TIMEOUT cycles without it set timeout_err, tx register unchanged, go to GAP.
REQ-027 CAPTURE (1 cycle, exactly one clk after filter_done): latch data_out into tx register; go to GAP.
REQ-028 GAP: on frame tick go to CONV.
REQ-029 Frame tick in any state other than IDLE/GAP SHALL set overrun, be ignored, and not disturb the current operation.
REQ-030 filter_done outside WAIT_DONE SHALL be ignored.
REQ-031 Latency: a sample received in frame N is transmitted on dac_sdata in frame N+1.
REQ-032 No arithmetic on samples; bit order and widths preserved exactly, no sign extension or truncation.

Reset
REQ-033 Reset SHALL asynchronously force: state IDLE, frame counter 0, adc_cs_n 1, sclk 0, dac_sdata 0, dac_ld 0, sample_trig 0, data_in 0, tx register 0, busy 0, overrun 0, timeout_err 0.
REQ-034 Reset mid-CONV SHALL abort the frame; no sample_trig or dac_ld SHALL follow before next frame tick after release.
REQ-035 overrun and timeout_err SHALL clear only on reset.

Verification
REQ-036 ADC model sends 0x800001, filter model returns filter_done 1 cycle after trig, data_out=0x123456 → data_in=0x800001 with single sample_trig; next frame dac_sdata shifts 0x123456 MSB first, dac_ld pulses once.
REQ-037 Timing: default params → adc_cs_n low exactly 96 cycles per frame, frame start every 256 cycles, 24 sclk rising edges.
REQ-038 filter_done never asserted → timeout_err set 16 cycles after trig; next frame transmits previous tx value.
REQ-039 Spurious filter_done in GAP → no tx register change, no error flags.
REQ-040 Reset asserted at bit 10 of CONV → all outputs at reset values immediately; first sample_trig after release only after full new frame.
REQ-041 Out-of-range FRAME_CYC=100 (debug build) → overrun sets at first missed tick, sample sequence otherwise correct.
